// File: rtl/clock_div_pkg.sv
// Shared definitions for the clock divider checker.
// - chan_state_e : per-channel checker state
// - DIVx_P       : expected periods (in clk cycles) of the divider outputs
// - *_DEF        : default checker parameters
package clock_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_MEAS,
    ST_LOCKED,
    ST_ERR
  } chan_state_e;

  localparam int unsigned DIV2_P = 2;
  localparam int unsigned DIV4_P = 4;
  localparam int unsigned DIV8_P = 8;

  localparam int unsigned LOCK_COUNT_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned TIMEOUT_DEF    = 32;

endpackage

// File: rtl/div_period_meter.sv
// Single-channel period/duty checker for one divider output.
// The input is treated as data in the clk domain: it is registered twice
// for edge detection, then the period and high time between rising edges
// are counted and compared against P and P/2.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en          : channel enable (0 -> IDLE, lock dropped, error kept)
//   clear_err   : clears the sticky error / leaves ERR
//   div_in      : monitored divider output
//   locked      : registered lock indication
//   locked_nxt  : next-cycle value of locked (for the aggregate lock flag)
//   err         : sticky error
//   period      : last measured period
module div_period_meter
  import clock_div_pkg::*;
#(
  parameter int unsigned P          = DIV2_P,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear_err,
  input  logic             div_in,
  output logic             locked,
  output logic             locked_nxt,
  output logic             err,
  output logic [CNT_W-1:0] period
);

  localparam int unsigned GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [CNT_W-1:0] P_C  = CNT_W'(P);
  localparam logic [CNT_W-1:0] H_C  = CNT_W'(P / 2);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LAST_GOOD = GW'(LOCK_COUNT - 1);

  logic             s0, s1;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [GW-1:0]    good_cnt, good_nxt;
  chan_state_e      state, state_nxt;
  logic             err_nxt;
  logic             rise, good_rise, timeout, fault;

  assign rise      = s0 & ~s1;
  assign good_rise = rise && (cnt == P_C) && (hcnt == H_C);
  assign timeout   = (cnt == TO_C);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = err;
    fault     = 1'b0;

    case (state)
      ST_IDLE: state_nxt = ST_ACQ;
      ST_ACQ: begin
        if (rise) begin
          state_nxt = ST_MEAS;
          good_nxt  = '0;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          if (good_rise) begin
            if (good_cnt == LAST_GOOD) state_nxt = ST_LOCKED;
            else                       good_nxt  = good_cnt + GW'(1);
          end else begin
            good_nxt = '0;
          end
        end else if (timeout) begin
          state_nxt = ST_ACQ;
        end
      end
      // A bad rise or a timeout in ERR counts as a fresh error, so a
      // coincident clear_err cannot release the channel.
      ST_LOCKED, ST_ERR: fault = rise ? ~good_rise : timeout;
      default: state_nxt = ST_IDLE;
    endcase

    if (fault) begin
      state_nxt = ST_ERR;
      err_nxt   = 1'b1;
    end else if (clear_err) begin
      err_nxt = 1'b0;
      if (state == ST_ERR) state_nxt = ST_ACQ;
    end

    if (!en) begin
      state_nxt = ST_IDLE;
      err_nxt   = err;
    end

    locked_nxt = (state_nxt == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0       <= 1'b0;
      s1       <= 1'b0;
      cnt      <= '0;
      hcnt     <= '0;
      good_cnt <= '0;
      state    <= ST_IDLE;
      err      <= 1'b0;
      locked   <= 1'b0;
      period   <= '0;
    end else begin
      s0 <= div_in;
      s1 <= s0;
      if (state != ST_IDLE) begin
        if (rise) begin
          cnt  <= CNT_W'(1);
          hcnt <= CNT_W'(1);
        end else begin
          if (cnt != '1)         cnt  <= cnt + CNT_W'(1);
          if (s0 && hcnt != '1)  hcnt <= hcnt + CNT_W'(1);
        end
      end
      if (rise && (state == ST_MEAS || state == ST_LOCKED || state == ST_ERR))
        period <= cnt;
      state    <= state_nxt;
      good_cnt <= good_nxt;
      err      <= err_nxt;
      locked   <= locked_nxt;
    end
  end

endmodule

// File: rtl/clock_div_checker.sv
// Checker for the three outputs of the clock divider (div2/div4/div8).
// Ports:
//   clk, rst              : source clock, synchronous active-high reset
//   en                    : checker enable
//   clear_err             : clears sticky errors
//   div_in[2:0]           : {clk8, clk4, clk2}
//   locked[2:0]           : per-channel lock
//   locked_all            : all channels locked
//   err[2:0]              : per-channel sticky error
//   period2/period4/period8 : last measured period per channel
module clock_div_checker
  import clock_div_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear_err,
  input  logic [2:0]       div_in,
  output logic [2:0]       locked,
  output logic             locked_all,
  output logic [2:0]       err,
  output logic [CNT_W-1:0] period2,
  output logic [CNT_W-1:0] period4,
  output logic [CNT_W-1:0] period8
);

  logic [2:0] locked_nxt;

  div_period_meter #(.P(DIV2_P), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_div2 (
    .clk(clk), .rst(rst), .en(en), .clear_err(clear_err), .div_in(div_in[0]),
    .locked(locked[0]), .locked_nxt(locked_nxt[0]), .err(err[0]), .period(period2)
  );

  div_period_meter #(.P(DIV4_P), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_div4 (
    .clk(clk), .rst(rst), .en(en), .clear_err(clear_err), .div_in(div_in[1]),
    .locked(locked[1]), .locked_nxt(locked_nxt[1]), .err(err[1]), .period(period4)
  );

  div_period_meter #(.P(DIV8_P), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_div8 (
    .clk(clk), .rst(rst), .en(en), .clear_err(clear_err), .div_in(div_in[2]),
    .locked(locked[2]), .locked_nxt(locked_nxt[2]), .err(err[2]), .period(period8)
  );

  // Built from the next-state lock bits so it rises with the last channel.
  always_ff @(posedge clk) begin
    if (rst) locked_all <= 1'b0;
    else     locked_all <= &locked_nxt;
  end

endmodule

// File: doc/clock_div_checker.md
Name: clock_div_checker

Overview:
- Monitors the three divided outputs of the clock divider (÷2, ÷4, ÷8) as data signals, sampled in the source `clk` domain.
- Per channel, measures the period and the high time in `clk` cycles.
- Declares lock after a run of correct periods, then flags a sticky error on any ratio/duty violation or a stuck output.
- Used as an on-chip self-check on the divider's receiving side and as a scoreboard in divider benches.

Parameters:
- LOCK_COUNT, 4: consecutive correct periods required to enter LOCKED.
- CNT_W, 8: width of the period and high-time counters and of the period outputs.
- TIMEOUT, 32: cycles without a rising edge that count as a stuck output. Must satisfy 8 < TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock; same clock that drives the divider.
- rst  in  1  synchronous, active-high reset.
- en  in  1  checker enable.
- clear_err  in  1  single-cycle pulse; clears sticky errors.
- div_in  in  3  bit0 = clk2, bit1 = clk4, bit2 = clk8 (divider outputs).
- locked  out  3  per-channel lock indication.
- locked_all  out  1  AND of `locked`.
- err  out  3  per-channel sticky error.
- period2  out  CNT_W  last measured ÷2 period.
- period4  out  CNT_W  last measured ÷4 period.
- period8  out  CNT_W  last measured ÷8 period.

Behaviour:
- Reset (synchronous, `rst` = 1 at a `clk` edge):
  - All outputs go to 0; all channel states go to IDLE; all counters go to 0.
  - `rst` wins over every other input.
- Channel i has expected period P = 2, 4 or 8 and expected high time H = P/2. All channels run the identical algorithm independently.
- Edge detection:
  - s0 <= div_in[i]; s1 <= s0; rise = s0 & ~s1.
  - This gives one cycle of latency from input to detection.
- Counters:
  - On rise: cnt <= 1 and hcnt <= 1.
  - Otherwise: cnt increments; hcnt increments while s0 = 1.
  - Both counters saturate at all-ones.
  - At a rise, cnt is the period and hcnt is the high time (cycles since the previous rise).
- Period output: on every rise outside IDLE/ACQ, the channel's period output <= cnt. It holds otherwise, including in IDLE.
- A rise is "good" when cnt == P and hcnt == H.
- State machine per channel:
  - IDLE: counters frozen. en = 1 -> ACQ.
  - ACQ: first rise -> MEAS with good_cnt = 0. The partial first period is discarded.
  - MEAS:
    - Good rise -> good_cnt++. Reaching LOCK_COUNT -> LOCKED.
    - Bad rise -> good_cnt = 0, stay in MEAS, no error.
    - cnt == TIMEOUT -> ACQ.
  - LOCKED:
    - locked[i] = 1.
    - Bad rise -> ERR and set err[i].
    - cnt == TIMEOUT -> ERR and set err[i].
  - ERR: holds. clear_err -> ACQ and clear err[i].
  - en = 0 in any state -> IDLE next cycle. locked[i] is cleared; err[i] is retained.
- Priority: rst > en = 0 > error detection > clear_err.
  - If clear_err coincides with a new error, err stays 1 and the state is ERR.
  - clear_err in a non-ERR state only clears err[i].
- locked_all is registered from the next-state locked values, so it asserts in the same cycle as the last channel's locked bit.

Decomposition:
- Shared package clock_div_pkg:
  - state encoding (IDLE, ACQ, MEAS, LOCKED, ERR);
  - expected periods DIV2_P = 2, DIV4_P = 4, DIV8_P = 8;
  - default LOCK_COUNT and TIMEOUT.
- One sub-module, div_period_meter, parameterised by expected period P. It contains the synchroniser, counters, FSM and the period register.
- The top instantiates div_period_meter three times and generates locked_all.

Test Plan:
1. Reset with en = 1 and div_in driven by a correct divider -> after rst deasserts, within 3 + 8·(LOCK_COUNT+1) cycles: locked = 3'b111, locked_all = 1, period2/4/8 = 2/4/8, err = 0.
2. After lock, hold clk8 low -> err[2] = 1 and locked[2] = 0 exactly TIMEOUT cycles after the last detected rise; channels 0–1 remain locked.
3. Before lock, drive bit1 with period 6 (3 high / 3 low) -> locked[1] never asserts, err[1] stays 0, period4 = 6.
4. After lock, drive bit2 with period 8 but 3 high / 5 low -> err[2] = 1 at the next rise, period8 = 8, locked_all = 0.
5. In ERR with correct inputs, pulse clear_err -> err[2] = 0 and re-lock after LOCK_COUNT good periods. Separately, pulse clear_err in the same cycle as a bad rise -> err stays 1.
6. rst asserted while LOCKED -> all outputs 0 the next cycle. Separately, en = 0 while LOCKED -> locked = 0, period outputs hold, err is unchanged.
